booth_mul32_seq: RTL
====================

Name: booth_mul32_seq

Overview:
- Iterative radix-4 Booth multiplier: one Booth digit per clock, accumulating a 2W-bit product from one shared partial-product generator.
- Sits beside the combinational array multiplier as the area-cheap option. Sequences operand load, digit selection, accumulation and result handoff.
- Valid/ready handshakes on both sides. Signed or unsigned multiply is selected per operation.

Parameters:
- WIDTH, 32, operand width; must be even and ≥4.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH/2+1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_signed  in  1  1 = signed×signed, 0 = unsigned×unsigned
- in_x  in  WIDTH  multiplicand
- in_y  in  WIDTH  multiplier (Booth-recoded)
- abort  in  1  synchronous cancel of the current operation
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*WIDTH  product
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, counter=0, accumulator=0.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load the operands and go to CALC.
  - xe = in_x extended to WIDTH+2 bits: sign extension if in_signed, zero extension otherwise.
  - ye = {ext(2 bits), in_y, 1'b0}, using the same extension rule; the appended 0 is y[-1].
  - N = WIDTH/2 if signed, WIDTH/2+1 if unsigned. N is latched.
  - acc=0, cnt=0.
- CALC, one digit per cycle:
  - Digit d from ye[2:0]: 000/111→0, 001/010→+x, 011→+2x, 100→−2x, 101/110→−x.
  - pp = d·xe, WIDTH+2 bits two's complement; negation is ~v+1.
  - acc += sign_extend(pp, 2*WIDTH+2) << 2*cnt. The addition is modulo 2^(2*WIDTH+2).
  - ye >>= 2 arithmetic, keeping the extension bit; cnt++.
  - When cnt==N-1 is processed, go to DONE.
- DONE:
  - out_valid=1 and out_p=acc[2*WIDTH-1:0], held stable until out_ready.
  - On out_valid&out_ready, go to IDLE; out_valid drops next cycle.
- Latency:
  - Accept on edge k gives out_valid high after edge k+N.
  - That is 16 cycles for signed and 17 for unsigned at WIDTH=32.
  - Throughput is one op per N+2 cycles with out_ready held high.
- in_ready is 1 only in IDLE. There is no overlap: a new op is not accepted in DONE, even when out_ready=1 in the same cycle.
- abort:
  - In CALC or DONE, go to IDLE next edge with no out_valid pulse; accumulator contents are discarded.
  - In IDLE, abort is ignored, and an in_valid in the same cycle is still accepted.
  - Abort has priority over out_ready in DONE.
- Reset mid-operation returns everything to reset values immediately; no product is emitted.
- Operands and in_signed are sampled only on the accept edge. Later changes on in_x/in_y have no effect.
- Boundary: signed −2^(W−1)·−2^(W−1) = 2^(2W−2) fits in 2W bits and must not wrap. This is guaranteed by the WIDTH+2 pp width and the wide accumulator.

Decomposition:
- Shared package booth_pkg:
  - Digit encoding enum: ZERO, P1, P2, M1, M2.
  - Function mapping a 3-bit window to a digit.
  - Localparam PPW = WIDTH+2.
  - FSM state enum.
- Sub-module booth_pp_gen (combinational):
  - Inputs are the 3-bit window and xe (PPW).
  - Output is pp (PPW), the full two's-complement value with carry-in resolved internally.
  - Instantiated once, time-multiplexed by the controller.

Test Plan:
1. Signed x=3, y=5 → out_p=0x0000_0000_0000_000F; out_valid exactly 16 cycles after accept.
2. Signed x=0xFFFF_FFFF, y=0xFFFF_FFFF (−1·−1) → 0x1. Signed x=0x8000_0000, y=0xFFFF_FFFF → 0x0000_0000_8000_0000.
3. Signed x=y=0x8000_0000 → 0x4000_0000_0000_0000. Unsigned x=y=0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001, with latency 17.
4. out_ready held low 10 cycles in DONE → out_p/out_valid stable, in_ready=0. Accept a new op only after the handshake completes plus 1 cycle.
5. abort at cnt=7, then a new op 0x1234_5678·0x9ABC_DEF0 (unsigned) → exactly one out_valid, carrying 0x0B00_EA4E_242D_2080; no stale result.
6. rst_n low mid-CALC (cnt=5), async → out_valid=0 and in_ready=1 with no clock edge. After release, 7·−9 signed → 0xFFFF_FFFF_FFFF_FFC1.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  // Default operand width; the partial product carries two extra bits so that
  // -2 * (most negative x) still fits without wrapping.
  localparam int DEF_WIDTH = 32;
  localparam int PPW       = DEF_WIDTH + 2;

  // Booth digit selected by one 3-bit multiplier window.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // Radix-4 recoding of the window {y[2i+1], y[2i], y[2i-1]}.
  function automatic booth_digit_e booth_digit(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: pp = digit(win) * xe, returned as a
// full two's-complement value (the +1 of the negation is resolved here).
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int W_PP = PPW
) (
  input  logic [2:0]      win,
  input  logic [W_PP-1:0] xe,
  output logic [W_PP-1:0] pp
);

  logic [W_PP-1:0] mag;
  logic            neg;

  // Select |d|*x, then negate for the minus digits.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (booth_digit(win))
      P1: mag = xe;
      P2: mag = {xe[W_PP-2:0], 1'b0};
      M1: begin
        mag = xe;
        neg = 1'b1;
      end
      M2: begin
        mag = {xe[W_PP-2:0], 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = neg ? (~mag + W_PP'(1)) : mag;
  end

endmodule

// File: rtl/booth_mul32_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for operands
//   CALC  | one Booth digit accumulated per cycle, cnt = digit index
//   DONE  | out_valid=1, product held until out_ready (or abort)
//
// WIDTH must be even and >= 4; 2^CNT_W must exceed WIDTH/2+1.
module booth_mul32_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int XW = WIDTH + 2;      // extended multiplicand / pp width
  localparam int YW = WIDTH + 3;      // extended multiplier plus y[-1]
  localparam int AW = 2 * WIDTH + 2;  // accumulator width

  // Index of the last digit: signed needs WIDTH/2 digits, unsigned one more
  // so the zero-extension bits are recoded as well.
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(WIDTH / 2);

  booth_state_e     state;
  logic [XW-1:0]    xe_q;
  logic [YW-1:0]    ye_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic [AW-1:0]    acc_q;

  logic [XW-1:0]    pp;
  logic [AW-1:0]    pp_ext;
  logic [AW-1:0]    acc_nxt;
  logic             y_ext;

  booth_pp_gen #(.W_PP(XW)) u_pp_gen (
    .win (ye_q[2:0]),
    .xe  (xe_q),
    .pp  (pp)
  );

  // Weight the current digit's partial product by 4^cnt and add it in.
  always_comb begin
    pp_ext  = {{(AW - XW){pp[XW-1]}}, pp};
    acc_nxt = acc_q + (pp_ext << {cnt_q, 1'b0});
    y_ext   = in_signed & in_y[WIDTH-1];
  end

  // Controller: operand load, digit iteration, result handoff and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_p     <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort is deliberately ignored here; a same-cycle request is taken.
          if (in_valid && in_ready) begin
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            xe_q     <= in_signed ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
            ye_q     <= {y_ext, y_ext, in_y, 1'b0};
            last_q   <= in_signed ? LAST_S : LAST_U;
            cnt_q    <= '0;
            acc_q    <= '0;
          end
        end

        CALC: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
          end else begin
            acc_q <= acc_nxt;
            ye_q  <= {ye_q[YW-1], ye_q[YW-1], ye_q[YW-1:2]};
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == last_q) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_p     <= acc_nxt[2*WIDTH-1:0];
            end
          end
        end

        DONE: begin
          // abort wins over out_ready; both leave without a further product.
          if (abort || out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
